// File: rtl/cp0_exception_commit_if.sv
// M/W-boundary bus between the pipeline and the CP0 exception-commit block.
// master = pipeline side (drives M-stage info, consumes flush/redirect/readback),
// slave  = CP0 side.
interface cp0_exception_commit_if;
  logic [4:0]  excode_i;
  logic [31:0] pc_m_i;
  logic        in_dslot_i;
  logic [31:0] bad_addr_i;
  logic        stall_m_i;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic [31:0] mtc0_wdata_i;
  logic [4:0]  mfc0_addr_i;
  logic [31:0] mfc0_rdata_o;
  logic [5:0]  ext_int_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  modport master (
    output excode_i, pc_m_i, in_dslot_i, bad_addr_i, stall_m_i,
           mtc0_we_i, mtc0_addr_i, mtc0_wdata_i, mfc0_addr_i, ext_int_i,
    input  mfc0_rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
  );

  modport slave (
    input  excode_i, pc_m_i, in_dslot_i, bad_addr_i, stall_m_i,
           mtc0_we_i, mtc0_addr_i, mtc0_wdata_i, mfc0_addr_i, ext_int_i,
    output mfc0_rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/cp0_exception_commit.sv
// CP0 exception commit: arbitrates interrupt / exception / ERET for the M-stage
// instruction, drives flush and redirect PC in the same cycle, and owns the
// BadVAddr, Count, Compare, Status, Cause and EPC registers.
// Optional feature macro: CP0_TIMER_INT_EN (Count==Compare timer interrupt on IP7).
// ExcCode sentinels: 5'h1F = no exception, 5'h1E = ERET.
module cp0_exception_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV  = 2
) (
  input logic                   clk,
  input logic                   rst,
  cp0_exception_commit_if.slave bus
);
  localparam logic [4:0] EXC_INT      = 5'h00;
  localparam logic [4:0] EXC_ADEL     = 5'h04;
  localparam logic [4:0] EXC_ADES     = 5'h05;
  localparam logic [4:0] EXC_ERET     = 5'h1E;
  localparam logic [4:0] EXC_NE       = 5'h1F;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [31:0]      badvaddr_q, badvaddr_d, count_q, count_d;
  logic [31:0]      compare_q, compare_d, epc_q, epc_d;
  logic [7:0]       status_im_q, status_im_d, cause_ip_q, cause_ip_d;
  logic             status_exl_q, status_exl_d, status_ie_q, status_ie_d;
  logic             cause_bd_q, cause_bd_d, ti_q, ti_d;
  logic [4:0]       cause_exc_q, cause_exc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             int_req, is_exc, is_eret, take_int, take_exc, take_eret;
  logic             wr_en, count_wr, tick;
  logic [31:0]      count_inc, status_w, cause_w;

  assign status_w     = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
  assign cause_w      = {cause_bd_q, ti_q, 14'b0, cause_ip_q, 1'b0, cause_exc_q, 2'b0};
  assign bus.status_o = status_w;
  assign bus.cause_o  = cause_w;
  assign bus.epc_o    = epc_q;

  // Commit arbitration, same-cycle flush/redirect and MFC0 readback.
  always_comb begin
    int_req   = status_ie_q & ~status_exl_q & (|(cause_ip_q & status_im_q));
    is_exc    = (bus.excode_i != EXC_NE) && (bus.excode_i != EXC_ERET);
    is_eret   = (bus.excode_i == EXC_ERET);
    take_int  = ~bus.stall_m_i & int_req;
    take_exc  = ~bus.stall_m_i & ~int_req & is_exc;
    take_eret = ~bus.stall_m_i & ~int_req & ~is_exc & is_eret;
    // The instruction that commits an exception/ERET never gets to write CP0.
    wr_en     = bus.mtc0_we_i & ~bus.stall_m_i & ~(take_int | take_exc | take_eret);
    bus.flush_o      = 1'b0;
    bus.new_pc_o     = '0;
    bus.mfc0_rdata_o = '0;
    if (!rst) begin
      if (take_int || take_exc) begin
        bus.flush_o  = 1'b1;
        bus.new_pc_o = EXC_VECTOR;
      end else if (take_eret) begin
        bus.flush_o  = 1'b1;
        bus.new_pc_o = epc_q;
      end
      case (bus.mfc0_addr_i)
        REG_BADVADDR: bus.mfc0_rdata_o = badvaddr_q;
        REG_COUNT:    bus.mfc0_rdata_o = count_q;
        REG_COMPARE:  bus.mfc0_rdata_o = compare_q;
        REG_STATUS:   bus.mfc0_rdata_o = status_w;
        REG_CAUSE:    bus.mfc0_rdata_o = cause_w;
        REG_EPC:      bus.mfc0_rdata_o = epc_q;
        default:      bus.mfc0_rdata_o = '0;
      endcase
    end
  end

  // Next-state for Count/timer, MTC0 writes, interrupt sampling and commit effects.
  always_comb begin
    badvaddr_d   = badvaddr_q;
    count_d      = count_q;
    compare_d    = compare_q;
    epc_d        = epc_q;
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_ip_d   = cause_ip_q;
    cause_exc_d  = cause_exc_q;
    div_d        = div_q;
    count_inc    = count_q + 32'd1;
    tick         = (div_q == DIV_LAST);
    count_wr     = wr_en && (bus.mtc0_addr_i == REG_COUNT);

    // A software Count write overrides a coincident tick and restarts the divider.
    if (count_wr) begin
      count_d = bus.mtc0_wdata_i;
      div_d   = '0;
    end else if (tick) begin
      count_d = count_inc;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

`ifdef CP0_TIMER_INT_EN
    ti_d = ti_q;
    if (wr_en && (bus.mtc0_addr_i == REG_COMPARE)) begin
      ti_d = 1'b0;
    end else if (tick && !count_wr && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end
`else
    ti_d = 1'b0;
`endif

    if (wr_en) begin
      case (bus.mtc0_addr_i)
        REG_COMPARE: compare_d = bus.mtc0_wdata_i;
        REG_STATUS: begin
          status_im_d  = bus.mtc0_wdata_i[15:8];
          status_exl_d = bus.mtc0_wdata_i[1];
          status_ie_d  = bus.mtc0_wdata_i[0];
        end
        REG_CAUSE:   cause_ip_d[1:0] = bus.mtc0_wdata_i[9:8];
        REG_EPC:     epc_d = bus.mtc0_wdata_i;
        default: ;
      endcase
    end

    // Hardware interrupt lines are level-sampled every cycle, stall or not.
    cause_ip_d[7:2] = {bus.ext_int_i[5] | ti_d, bus.ext_int_i[4:0]};

    if (take_int || take_exc) begin
      cause_exc_d = take_int ? EXC_INT : bus.excode_i;
      // Nested exceptions keep the original return point.
      if (!status_exl_q) begin
        epc_d      = bus.in_dslot_i ? (bus.pc_m_i - 32'd4) : bus.pc_m_i;
        cause_bd_d = bus.in_dslot_i;
      end
      status_exl_d = 1'b1;
      if (take_exc && ((bus.excode_i == EXC_ADEL) || (bus.excode_i == EXC_ADES))) begin
        badvaddr_d = bus.bad_addr_i;
      end
    end else if (take_eret) begin
      status_exl_d = 1'b0;
    end
  end

  // CP0 state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q   <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      epc_q        <= '0;
      status_im_q  <= '0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_ip_q   <= '0;
      cause_exc_q  <= '0;
      ti_q         <= 1'b0;
      div_q        <= '0;
    end else begin
      badvaddr_q   <= badvaddr_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      epc_q        <= epc_d;
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_ip_q   <= cause_ip_d;
      cause_exc_q  <= cause_exc_d;
      ti_q         <= ti_d;
      div_q        <= div_d;
    end
  end
endmodule

// File: tb/tb_cp0_exception_commit.sv
// Self-checking bench for cp0_exception_commit: directed scenarios followed by
// random traffic, all checked against a word-level CP0 register-file model.
module tb_cp0_exception_commit;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int DIV = 2;
  localparam logic [4:0] C_INT = 5'h00, C_ADEL = 5'h04, C_ADES = 5'h05, C_SYS = 5'h08;
  localparam logic [4:0] C_BP = 5'h09, C_RI = 5'h0A, C_OV = 5'h0C;
  localparam logic [4:0] C_ERET = 5'h1E, C_NE = 5'h1F;
`ifdef CP0_TIMER_INT_EN
  localparam logic TI_EXP = 1'b1;
`else
  localparam logic TI_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exception_commit_if bus();
  cp0_exception_commit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [31:0] m_reg [0:31];
  int m_clks;
  logic [31:0] obs_flush, obs_newpc, obs_mfc0, saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Which CP0 bits software may write, per register number.
  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
      5'd12:              return 32'h0000_FF03;
      5'd13:              return 32'h0000_0300;
      default:            return 32'h0;
    endcase
  endfunction

  function automatic bit implemented(input logic [4:0] a);
    return (a == 5'd8) || (a == 5'd9) || (a == 5'd11) || (a == 5'd12) || (a == 5'd13) || (a == 5'd14);
  endfunction

  // 0 none, 1 interrupt, 2 exception, 3 eret
  function automatic int commit_kind();
    logic [31:0] st;
    st = m_reg[12];
    if (rst || bus.stall_m_i) return 0;
    if (st[0] && !st[1] && ((m_reg[13][15:8] & st[15:8]) != 8'h0)) return 1;
    if (bus.excode_i != C_NE && bus.excode_i != C_ERET) return 2;
    if (bus.excode_i == C_ERET) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[12] = 32'h0040_0000;
    m_clks = 0;
  endtask

  task automatic model_edge();
    int kind;
    bit wr;
    logic [4:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    kind = commit_kind();
    wr = bus.mtc0_we_i && !bus.stall_m_i && (kind == 0);
    a = bus.mtc0_addr_i;
    if (wr && a == 5'd9) begin
      m_reg[9] = bus.mtc0_wdata_i;
      m_clks = 0;
    end else begin
      m_clks++;
      if (m_clks == DIV) begin
        m_clks = 0;
        m_reg[9] = m_reg[9] + 32'd1;
`ifdef CP0_TIMER_INT_EN
        if (m_reg[9] == m_reg[11]) m_reg[13][30] = 1'b1;
`endif
      end
    end
    if (wr && a != 5'd9) begin
      m_reg[a] = (m_reg[a] & ~wmask(a)) | (bus.mtc0_wdata_i & wmask(a));
`ifdef CP0_TIMER_INT_EN
      if (a == 5'd11) m_reg[13][30] = 1'b0;
`endif
    end
    m_reg[13][15:10] = {bus.ext_int_i[5] | m_reg[13][30], bus.ext_int_i[4:0]};
    if (kind == 1 || kind == 2) begin
      m_reg[13][6:2] = (kind == 1) ? C_INT : bus.excode_i;
      if (!m_reg[12][1]) begin
        m_reg[14] = bus.in_dslot_i ? bus.pc_m_i - 32'd4 : bus.pc_m_i;
        m_reg[13][31] = bus.in_dslot_i;
      end
      m_reg[12][1] = 1'b1;
      if (kind == 2 && (bus.excode_i == C_ADEL || bus.excode_i == C_ADES)) m_reg[8] = bus.bad_addr_i;
    end else if (kind == 3) begin
      m_reg[12][1] = 1'b0;
    end
  endtask

  // One clock: inputs already driven (after a negedge); check comb outputs,
  // take the edge, update the model, check state.
  task automatic cycle(input string tag);
    int k;
    logic [31:0] exp_pc, exp_rd;
    #1;
    k = commit_kind();
    exp_pc = (k == 1 || k == 2) ? VEC : (k == 3) ? m_reg[14] : 32'h0;
    exp_rd = (!rst && implemented(bus.mfc0_addr_i)) ? m_reg[bus.mfc0_addr_i] : 32'h0;
    obs_flush = {31'b0, bus.flush_o};
    obs_newpc = bus.new_pc_o;
    obs_mfc0  = bus.mfc0_rdata_o;
    chk({tag, ".flush"}, obs_flush, {31'b0, k != 0});
    chk({tag, ".new_pc"}, obs_newpc, exp_pc);
    chk({tag, ".mfc0"}, obs_mfc0, exp_rd);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".status"}, bus.status_o, m_reg[12]);
    chk({tag, ".cause"}, bus.cause_o, m_reg[13]);
    chk({tag, ".epc"}, bus.epc_o, m_reg[14]);
    txn++;
    $display("txn %0d %s flush=%0b new_pc=%h status=%h cause=%h epc=%h",
             txn, tag, obs_flush[0], obs_newpc, bus.status_o, bus.cause_o, bus.epc_o);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.excode_i = C_NE;   bus.pc_m_i = 32'h0;     bus.in_dslot_i = 1'b0;
    bus.bad_addr_i = 32'h0; bus.stall_m_i = 1'b0;  bus.mtc0_we_i = 1'b0;
    bus.mtc0_addr_i = 5'd0; bus.mtc0_wdata_i = 32'h0; bus.mfc0_addr_i = 5'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.mtc0_we_i = 1'b1; bus.mtc0_addr_i = a; bus.mtc0_wdata_i = d;
    cycle("mtc0");
    idle();
  endtask

  task automatic trap(input logic [4:0] code, input logic [31:0] pc, input logic ds, input string tag);
    idle();
    bus.excode_i = code; bus.pc_m_i = pc; bus.in_dslot_i = ds;
    cycle(tag);
    idle();
  endtask

  function automatic logic [4:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return C_NE;
    if (r == 6) return C_ERET;
    if (r == 7) return ($urandom_range(0, 1) == 0) ? C_ADEL : C_ADES;
    return 5'($urandom_range(0, 29));
  endfunction

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 7))
      0: return 5'd8;  1: return 5'd9;  2: return 5'd11; 3: return 5'd12;
      4: return 5'd13; 5: return 5'd14; 6: return 5'd5;  default: return 5'd0;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.excode_i = 5'($urandom); bus.pc_m_i = $urandom; bus.in_dslot_i = 1'b1;
    bus.bad_addr_i = $urandom; bus.stall_m_i = 1'b0; bus.mtc0_we_i = 1'b1;
    bus.mtc0_addr_i = 5'd14; bus.mtc0_wdata_i = $urandom; bus.mfc0_addr_i = 5'd12;
    bus.ext_int_i = 6'h3F;
    model_reset();
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;
    bus.ext_int_i = 6'h0;
    idle();
    chk("reset.status", bus.status_o, 32'h0040_0000);
    chk("reset.epc", bus.epc_o, 32'h0);
    cycle("idle");
    chk("reset.cause", bus.cause_o, 32'h0);

    // Arithmetic overflow, not in a delay slot
    trap(C_OV, 32'h8000_0100, 1'b0, "ov");
    chk("ov.flush", obs_flush, 32'h1);
    chk("ov.new_pc", obs_newpc, 32'hBFC0_0380);
    chk("ov.exccode", {27'b0, bus.cause_o[6:2]}, 32'h0C);
    chk("ov.epc", bus.epc_o, 32'h8000_0100);
    chk("ov.exl", {31'b0, bus.status_o[1]}, 32'h1);
    trap(C_ERET, 32'h0, 1'b0, "eret0");
    chk("eret0.new_pc", obs_newpc, 32'h8000_0100);

    // ERET to a software-written EPC with EXL set
    mtc0(5'd14, 32'h8000_0040);
    mtc0(5'd12, 32'h0000_0002);
    chk("eret.exl_before", {31'b0, bus.status_o[1]}, 32'h1);
    trap(C_ERET, 32'h0, 1'b0, "eret");
    chk("eret.flush", obs_flush, 32'h1);
    chk("eret.new_pc", obs_newpc, 32'h8000_0040);
    chk("eret.exl_after", {31'b0, bus.status_o[1]}, 32'h0);

    // Address error in a delay slot
    idle();
    bus.excode_i = C_ADEL; bus.pc_m_i = 32'h8000_0204; bus.in_dslot_i = 1'b1; bus.bad_addr_i = 32'h0000_1003;
    cycle("adel");
    idle();
    chk("adel.epc", bus.epc_o, 32'h8000_0200);
    chk("adel.bd", {31'b0, bus.cause_o[31]}, 32'h1);
    bus.mfc0_addr_i = 5'd8;
    cycle("rd_badvaddr");
    chk("adel.badvaddr", obs_mfc0, 32'h0000_1003);
    trap(C_ERET, 32'h0, 1'b0, "eret1");

    // Interrupt beats a concurrent syscall
    bus.ext_int_i = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    trap(C_SYS, 32'h8000_0300, 1'b0, "int");
    bus.ext_int_i = 6'b0;
    chk("int.new_pc", obs_newpc, 32'hBFC0_0380);
    chk("int.exccode", {27'b0, bus.cause_o[6:2]}, 32'h00);
    chk("int.epc", bus.epc_o, 32'h8000_0300);

    // Nested exception keeps EPC
    trap(C_BP, 32'h8000_0400, 1'b1, "nested");
    chk("nested.exccode", {27'b0, bus.cause_o[6:2]}, 32'h09);
    chk("nested.epc", bus.epc_o, 32'h8000_0300);

    // Stalled RI with an MTC0: nothing happens
    saved = bus.cause_o;
    idle();
    bus.excode_i = C_RI; bus.stall_m_i = 1'b1; bus.pc_m_i = 32'h8000_0500;
    bus.mtc0_we_i = 1'b1; bus.mtc0_addr_i = 5'd14; bus.mtc0_wdata_i = 32'h1234_5678;
    cycle("stall");
    idle();
    chk("stall.flush", obs_flush, 32'h0);
    chk("stall.epc", bus.epc_o, 32'h8000_0300);
    chk("stall.cause", bus.cause_o, saved);

    // MTC0 on the committing instruction is dropped
    bus.excode_i = C_ERET;
    bus.mtc0_we_i = 1'b1; bus.mtc0_addr_i = 5'd14; bus.mtc0_wdata_i = 32'hDEAD_0000;
    cycle("eret_mtc0");
    idle();
    chk("eret_mtc0.new_pc", obs_newpc, 32'h8000_0300);
    chk("eret_mtc0.epc", bus.epc_o, 32'h8000_0300);
    mtc0(5'd12, 32'h0);

    // Timer: Compare=5, Count restarted at 0
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 9; i++) cycle("timer_wait");
    chk("timer.ti_early", {31'b0, bus.cause_o[30]}, 32'h0);
    cycle("timer_hit");
    chk("timer.ti", {31'b0, bus.cause_o[30]}, {31'b0, TI_EXP});
    mtc0(5'd11, 32'd100);
    chk("timer.ti_clear", {31'b0, bus.cause_o[30]}, 32'h0);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    bus.mfc0_addr_i = 5'd9;
    cycle("wrap0");
    chk("wrap.before", obs_mfc0, 32'hFFFF_FFFF);
    cycle("wrap1");
    cycle("wrap2");
    chk("wrap.after", obs_mfc0, 32'h0);

    // Unimplemented register and read-only BadVAddr
    mtc0(5'd5, 32'hCAFE_F00D);
    mtc0(5'd8, 32'hFFFF_FFFF);
    bus.mfc0_addr_i = 5'd5;
    cycle("rd_unimpl");
    chk("unimpl.read", obs_mfc0, 32'h0);
    bus.mfc0_addr_i = 5'd8;
    cycle("rd_badvaddr2");
    chk("badvaddr.ro", obs_mfc0, 32'h0000_1003);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.excode_i     = rand_code();
      bus.pc_m_i       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.in_dslot_i   = 1'($urandom_range(0, 1));
      bus.bad_addr_i   = $urandom;
      bus.stall_m_i    = ($urandom_range(0, 3) == 0);
      bus.mtc0_we_i    = ($urandom_range(0, 3) == 0);
      bus.mtc0_addr_i  = rand_reg();
      bus.mtc0_wdata_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
      bus.mfc0_addr_i  = rand_reg();
      bus.ext_int_i    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
